uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 83 ++++++++
 tb/tb_uart_rx_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver (Rx -> ready/data, parity_err/frame_err/overrun, cleared by ready_clr)
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 Rx,
  input  logic                 clken,
  input  logic                 ready_clr,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M = OVERSAMPLE / 2;
  state_t state, state_n;
  logic rx_m, rx_s, s_a, s_b, vote, at_v, at_e, last_stop, done, sidx, perr, ferr;
  logic [TW-1:0] t;
  logic [BW-1:0] idx;
  logic [DATA_BITS-1:0] scratch;
  always_comb begin
    vote = (s_a & s_b) | (rx_s & (s_a | s_b));
    at_v = clken && t == TW'(M + 1);
    at_e = clken && t == TW'(OVERSAMPLE - 1);
    last_stop = STOP_BITS == 1 || sidx;
    done = state == STOP && at_v && last_stop;
    state_n = state;
    case (state)
      IDLE:    state_n = clken && !rx_s ? START : IDLE;
      START:   state_n = at_v && vote ? IDLE : at_e ? DATA : START;
      DATA:    state_n = at_e && idx == BW'(DATA_BITS - 1) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     state_n = at_e ? STOP : PAR;
      STOP:    state_n = done ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      {rx_m, rx_s} <= 2'b11;
      state <= IDLE;
      t <= '0;
      idx <= '0;
      {sidx, s_a, s_b, perr, ferr} <= '0;
      scratch <= '0;
      {ready, parity_err, frame_err, overrun} <= '0;
      data <= '0;
    end else begin
      {rx_m, rx_s} <= {Rx, rx_m};
      state <= state_n;
      ready <= done | (ready & ~ready_clr);
      overrun <= ~ready_clr & (overrun | (done & ready));
      if (done) begin
        data <= scratch;
        parity_err <= perr;
        frame_err <= ferr | ~vote;
      end else if (ready_clr) begin
        {parity_err, frame_err} <= 2'b00;
      end
      if (clken) begin
        t <= state_n == IDLE ? '0 : t + 1'b1;
        if (t == TW'(M - 1)) s_a <= rx_s;
        if (t == TW'(M)) s_b <= rx_s;
        if (state == START && at_e) begin
          idx <= '0;
          scratch <= '0;
          {sidx, perr, ferr} <= '0;
        end
        if (state == DATA && at_v) scratch[idx] <= vote;
        if (state == DATA && at_e) idx <= idx + 1'b1;
        if (state == PAR && at_v) perr <= vote ^ (PARITY == 2 ? ^scratch : ~^scratch);
        if (state == STOP && at_v && !vote) ferr <= 1'b1;
        if (state == STOP && at_e) sidx <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frame checks of uart_rx_param against a frame-level model
module tb_uart_rx_param;
  logic clk_50m = 1'b0;
  logic rst = 1'b1;
  logic clken = 1'b0;
  logic ready_clr = 1'b0;
  logic [1:0] ckd = '0;
  logic rx [2] = '{1'b1, 1'b1};
  logic rdy [2];
  logic pe [2];
  logic fe [2];
  logic ov [2];
  logic [7:0] dat [2];
  logic m_rdy [2];
  logic m_ov [2];
  logic prev_rdy;
  int errs = 0;
  int checks = 0;
  int tick_no = 0;
  int rise_at = -1;

  uart_rx_param u0 (
    .clk_50m(clk_50m), .rst(rst), .Rx(rx[0]), .clken(clken), .ready_clr(ready_clr),
    .ready(rdy[0]), .data(dat[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0])
  );
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk_50m(clk_50m), .rst(rst), .Rx(rx[1]), .clken(clken), .ready_clr(ready_clr),
    .ready(rdy[1]), .data(dat[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1])
  );

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) begin
    ckd <= ckd + 2'd1;
    clken <= ckd == 2'd3;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  function automatic int exp_rise(input int w);
    return w == 0 ? (1 + 8 + 0 + 1 - 1) * 16 + 16 / 2 + 1 : (1 + 8 + 1 + 2 - 1) * 8 + 8 / 2 + 1;
  endfunction

  task automatic wait_tick(input logic clr);
    do @(negedge clk_50m); while (!clken);
    ready_clr = clr;
    @(posedge clk_50m);
    #1 ready_clr = 1'b0;
  endtask

  task automatic line(input int w, input logic v, input int n, input int clr_at);
    for (int i = 0; i < n; i++) begin
      rx[w] = v;
      wait_tick(tick_no == clr_at);
      if (!prev_rdy && rdy[w] && rise_at < 0) rise_at = tick_no;
      prev_rdy = rdy[w];
      tick_no++;
    end
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input logic pb, input logic [1:0] st,
                            input int sp, input int clr_at);
    int os;
    int nb;
    logic [11:0] bits;
    os = w == 0 ? 16 : 8;
    nb = w == 0 ? 10 : 12;
    bits = w == 0 ? {2'b11, st[0], d, 1'b0} : {st, pb, d, 1'b0};
    wait_tick(1'b0);
    tick_no = 0;
    rise_at = -1;
    prev_rdy = rdy[w];
    for (int b = 0; b < nb; b++) begin
      if (b == sp) begin
        line(w, bits[b], os / 2, clr_at);
        line(w, ~bits[b], 1, clr_at);
        line(w, bits[b], os / 2 - 1, clr_at);
      end else if (b == nb - 1) begin
        line(w, bits[b], os / 2 + 2, clr_at);
        line(w, 1'b1, os / 2 - 2, clr_at);
      end else begin
        line(w, bits[b], os, clr_at);
      end
    end
    line(w, 1'b1, 2, clr_at);
  endtask

  task automatic pulse_clr;
    @(negedge clk_50m) ready_clr = 1'b1;
    @(negedge clk_50m) ready_clr = 1'b0;
    m_rdy = '{1'b0, 1'b0};
    m_ov = '{1'b0, 1'b0};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1 rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if ({rdy[w], pe[w], fe[w], ov[w]} !== 4'b0000) begin
        errs++; $display("FAIL reset_flags dut%0d got %b exp 0000", w, {rdy[w], pe[w], fe[w], ov[w]});
      end
      checks++;
      if (dat[w] !== 8'h00) begin errs++; $display("FAIL reset_data dut%0d got %h exp 00", w, dat[w]); end
    end
    repeat (40) wait_tick(1'b0);
    checks++;
    if (rdy[0] !== 1'b0 || rdy[1] !== 1'b0) begin
      errs++; $display("FAIL idle_ready got %b%b exp 00", rdy[0], rdy[1]);
    end
  endtask

  task automatic test_basic;
    logic [7:0] v [2] = '{8'h55, 8'hA3};
    for (int i = 0; i < 2; i++) begin
      send_frame(0, v[i], 1'b0, 2'b11, -1, -1);
      checks++;
      if (rise_at != exp_rise(0)) begin errs++; $display("FAIL basic_rise got %0d exp %0d", rise_at, exp_rise(0)); end
      checks++;
      if (dat[0] !== v[i]) begin errs++; $display("FAIL basic_data got %h exp %h", dat[0], v[i]); end
      checks++;
      if ({rdy[0], pe[0], fe[0], ov[0]} !== 4'b1000) begin
        errs++; $display("FAIL basic_flags got %b exp 1000", {rdy[0], pe[0], fe[0], ov[0]});
      end
      pulse_clr;
      checks++;
      if (rdy[0] !== 1'b0) begin errs++; $display("FAIL basic_clr got %b exp 0", rdy[0]); end
    end
  endtask

  task automatic test_glitch;
    wait_tick(1'b0);
    tick_no = 0;
    rise_at = -1;
    prev_rdy = rdy[0];
    line(0, 1'b0, 4, -1);
    line(0, 1'b1, 12, -1);
    checks++;
    if (rdy[0] !== 1'b0 || rise_at != -1) begin errs++; $display("FAIL glitch_ready got %b exp 0", rdy[0]); end
    send_frame(0, 8'h3C, 1'b0, 2'b11, -1, -1);
    checks++;
    if (dat[0] !== 8'h3C || rise_at != exp_rise(0)) begin
      errs++; $display("FAIL glitch_next got %h@%0d exp 3c@%0d", dat[0], rise_at, exp_rise(0));
    end
    pulse_clr;
  endtask

  task automatic test_parity;
    for (int i = 0; i < 2; i++) begin
      send_frame(1, 8'h07, 1'(i), 2'b11, -1, -1);
      checks++;
      if (rise_at != exp_rise(1)) begin errs++; $display("FAIL par_rise got %0d exp %0d", rise_at, exp_rise(1)); end
      checks++;
      if (dat[1] !== 8'h07) begin errs++; $display("FAIL par_data got %h exp 07", dat[1]); end
      checks++;
      if (pe[1] !== 1'(1 - i) || fe[1] !== 1'b0) begin
        errs++; $display("FAIL par_err pb=%0d got pe=%b fe=%b exp pe=%b fe=0", i, pe[1], fe[1], 1'(1 - i));
      end
      pulse_clr;
    end
  endtask

  task automatic test_framing;
    send_frame(0, 8'hFF, 1'b0, 2'b10, -1, -1);
    checks++;
    if ({dat[0], rdy[0], fe[0]} !== {8'hFF, 2'b11}) begin
      errs++; $display("FAIL frame_1stop got %h r=%b fe=%b exp ff r=1 fe=1", dat[0], rdy[0], fe[0]);
    end
    pulse_clr;
    send_frame(1, 8'h0F, 1'b0, 2'b10, -1, -1);
    checks++;
    if ({dat[1], rdy[1], fe[1], pe[1]} !== {8'h0F, 3'b110}) begin
      errs++; $display("FAIL frame_2stop got %h r=%b fe=%b pe=%b exp 0f r=1 fe=1 pe=0", dat[1], rdy[1], fe[1], pe[1]);
    end
    pulse_clr;
  endtask

  task automatic test_back_to_back;
    send_frame(0, 8'h11, 1'b0, 2'b11, -1, -1);
    send_frame(0, 8'h22, 1'b0, 2'b11, -1, -1);
    checks++;
    if ({dat[0], rdy[0], ov[0]} !== {8'h22, 2'b11}) begin
      errs++; $display("FAIL b2b_overrun got %h r=%b ov=%b exp 22 r=1 ov=1", dat[0], rdy[0], ov[0]);
    end
    send_frame(0, 8'h33, 1'b0, 2'b11, -1, exp_rise(0));
    checks++;
    if ({dat[0], rdy[0], ov[0]} !== {8'h33, 2'b10}) begin
      errs++; $display("FAIL b2b_clr_done got %h r=%b ov=%b exp 33 r=1 ov=0", dat[0], rdy[0], ov[0]);
    end
    pulse_clr;
  endtask

  task automatic test_spike;
    int sp [2] = '{1, 6};
    for (int i = 0; i < 2; i++) begin
      send_frame(0, 8'h0F, 1'b0, 2'b11, sp[i], -1);
      checks++;
      if (dat[0] !== 8'h0F || pe[0] !== 1'b0 || fe[0] !== 1'b0) begin
        errs++; $display("FAIL spike_bit%0d got %h exp 0f", sp[i] - 1, dat[0]);
      end
      if (i == 0) pulse_clr;
    end
  endtask

  task automatic test_reset_mid;
    wait_tick(1'b0);
    line(0, 1'b0, 16, -1);
    line(0, 1'b1, 40, -1);
    rx[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk_50m);
    #1 rst = 1'b0;
    m_rdy = '{1'b0, 1'b0};
    m_ov = '{1'b0, 1'b0};
    checks++;
    if ({dat[0], rdy[0], pe[0], fe[0], ov[0]} !== 12'h000) begin
      errs++; $display("FAIL rst_mid got %h %b exp 00 0000", dat[0], {rdy[0], pe[0], fe[0], ov[0]});
    end
    send_frame(0, 8'hC3, 1'b0, 2'b11, -1, -1);
    checks++;
    if (dat[0] !== 8'hC3 || rise_at != exp_rise(0)) begin
      errs++; $display("FAIL rst_next got %h@%0d exp c3@%0d", dat[0], rise_at, exp_rise(0));
    end
    pulse_clr;
  endtask

  task automatic test_random;
    int w;
    int sp;
    logic [7:0] d;
    logic pb;
    logic [1:0] st;
    logic was_rdy;
    logic e_pe;
    logic e_fe;
    for (int i = 0; i < 24; i++) begin
      w = $urandom_range(0, 1);
      d = 8'($urandom);
      pb = 1'($urandom);
      st = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b11;
      sp = $urandom_range(0, 3) == 0 ? $urandom_range(1, 8) : -1;
      was_rdy = m_rdy[w];
      send_frame(w, d, pb, st, sp, -1);
      m_ov[w] = m_ov[w] | m_rdy[w];
      m_rdy[w] = 1'b1;
      e_pe = w == 1 && (($countones(d) + int'(pb)) % 2 == 1);
      e_fe = w == 0 ? !st[0] : !(st[0] && st[1]);
      checks++;
      if (dat[w] !== d) begin errs++; $display("FAIL rnd_data #%0d dut%0d got %h exp %h", i, w, dat[w], d); end
      checks++;
      if ({rdy[w], pe[w], fe[w], ov[w]} !== {m_rdy[w], e_pe, e_fe, m_ov[w]}) begin
        errs++; $display("FAIL rnd_flags #%0d dut%0d got %b exp %b", i, w,
                         {rdy[w], pe[w], fe[w], ov[w]}, {m_rdy[w], e_pe, e_fe, m_ov[w]});
      end
      if (!was_rdy) begin
        checks++;
        if (rise_at != exp_rise(w)) begin
          errs++; $display("FAIL rnd_rise #%0d dut%0d got %0d exp %0d", i, w, rise_at, exp_rise(w));
        end
      end
      if ($urandom_range(0, 1) == 1) pulse_clr;
    end
  endtask

  initial begin
    m_rdy = '{1'b0, 1'b0};
    m_ov = '{1'b0, 1'b0};
    test_reset;
    test_basic;
    test_glitch;
    test_parity;
    test_framing;
    test_back_to_back;
    test_spike;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
